uart8_receiver: RTL and testbench

8-bit UART receiver, the receive-side counterpart of the codebase's 8-bit transmitter. It oversamples the serial line at 16 clocks per bit and mid-bit samples one start bit, 8 data bits LSB-first, an optional even parity bit and one stop bit. Each good byte is pushed into the downstream RX FIFO with a one-cycle write strobe. Framing, parity and overrun conditions are reported as single-cycle status pulses.

---
 rtl/uart8_rx_if.sv | 28 ++
 rtl/uart8_receiver.sv | 195 +++++++++++++++++++
 tb/tb_uart8_receiver.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart8_rx_if.sv
// uart8_rx_if: bundles the receiver's serial input, enable and FIFO-full
// input with its byte output and status pulses.
//   en, in, is_fifo_full               : into the receiver
//   out, fifo_wr_en, done, busy,
//   frame_err, parity_err, overrun     : out of the receiver
// The receiver uses the slave modport; the driving side uses master.
interface uart8_rx_if;
  logic       en;
  logic       in;
  logic       is_fifo_full;
  logic [7:0] out;
  logic       fifo_wr_en;
  logic       done;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    output en, in, is_fifo_full,
    input  out, fifo_wr_en, done, busy, frame_err, parity_err, overrun
  );

  modport slave (
    input  en, in, is_fifo_full,
    output out, fifo_wr_en, done, busy, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart8_receiver.sv
// uart8_receiver: 8-bit UART receiver, 16x oversampled, mid-bit sampling of
// start, 8 data bits (LSB first), optional even parity and one stop bit.
// Good bytes are written to the downstream FIFO with a one-cycle strobe;
// framing/parity/overrun conditions are reported as one-cycle pulses.
// Ports:
//   clk   : oversampling clock (CLKS_PER_BIT x baud)
//   rst   : asynchronous active-high reset
//   rx_if : uart8_rx_if.slave (en, in, is_fifo_full -> out, fifo_wr_en,
//           done, busy, frame_err, parity_err, overrun)
// Build option: define UART_RX_PARITY_EN to add the even-parity bit.
module uart8_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SAMPLE_POINT = 7
) (
  input  logic       clk,
  input  logic       rst,
  uart8_rx_if.slave  rx_if
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       out_q, out_d;
  logic             wr_q, wr_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             rx_s;
  logic             parity_ok;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  assign rx_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit XOR to zero.
  assign parity_ok = ~(^shift_q ^ par_q);
`else
  assign parity_ok = 1'b1;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      out_q   <= 8'd0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], rx_if.in};
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    out_d   = out_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (rx_if.en && !rx_s) state_d = START_BIT;
      end
      START_BIT: begin
        if (cnt_q == CNT_SAMPLE && rx_s) begin
          // Line back high mid start bit: glitch, not a frame.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DATA_BITS;
          cnt_d   = '0;
        end
      end
      DATA_BITS: begin
        if (cnt_q == CNT_SAMPLE) shift_d[idx_q] = rx_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY_BIT;
`else
            state_d = STOP_BIT;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: begin
        if (cnt_q == CNT_SAMPLE) par_d = rx_s;
        if (cnt_q == CNT_LAST) begin
          state_d = STOP_BIT;
          cnt_d   = '0;
        end
      end
`endif
      STOP_BIT: begin
        // Leave at mid stop bit so the next start edge is not missed.
        if (cnt_q == CNT_SAMPLE) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d  = !parity_ok;
`endif
          if (rx_s && parity_ok) begin
            if (rx_if.is_fifo_full) begin
              ovr_d = 1'b1;
            end else begin
              out_d = shift_q;
              wr_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rx_if.out        = out_q;
  assign rx_if.fifo_wr_en = wr_q;
  assign rx_if.done       = done_q;
  assign rx_if.busy       = busy_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = perr_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart8_receiver.sv
// tb_uart8_receiver: directed bench for uart8_receiver at 16 clocks/bit.
// Line is driven on the falling edge, outputs sampled 1 time unit after
// the rising edge. Cycle c = rising edge number counted from the first
// drive of the start bit; the start edge reaches the FSM at c=3, so done
// is expected at c = 3 + 152 (or 3 + 168 with parity).
module tb_uart8_receiver;

`ifdef UART_RX_PARITY_EN
  localparam int NBITS    = 11;
  localparam int EXP_DONE = 3 + 168;
`else
  localparam int NBITS    = 10;
  localparam int EXP_DONE = 3 + 152;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;

  int          done_cyc;
  int          n_done;
  int          n_wr;
  logic [7:0]  cap_out;
  logic        cap_wr, cap_fe, cap_pe, cap_ov, cap_busy;

  uart8_rx_if bus();

  uart8_receiver #(.CLKS_PER_BIT(16), .SAMPLE_POINT(7)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out"},  32'(bus.out), 32'h0);
    check({tag, "_wr"},   32'(bus.fifo_wr_en), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_fe"},   32'(bus.frame_err), 32'h0);
    check({tag, "_pe"},   32'(bus.parity_err), 32'h0);
    check({tag, "_ov"},   32'(bus.overrun), 32'h0);
  endtask

  // Idle line for n cycles; no pulses may appear.
  task automatic idle(input int n, input string tag);
    int nd = 0;
    int nw = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in = 1'b1;
      @(posedge clk);
      #1;
      if (bus.done) nd++;
      if (bus.fifo_wr_en) nw++;
    end
    check({tag, "_idle_done"}, 32'(nd), 32'd0);
    check({tag, "_idle_wr"},   32'(nw), 32'd0);
  endtask

  // Transmit one frame; rst_at>0 asserts reset at that cycle and aborts.
  task automatic run_frame(input logic [7:0] data, input logic stop_v,
                           input logic par_v, input int rst_at);
    logic [NBITS-1:0] bits;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
    bits[9]   = par_v;
    bits[10]  = stop_v;
`else
    bits[9]   = stop_v;
    if (par_v) bits[9] = stop_v;
`endif
    done_cyc = 0;
    n_done   = 0;
    n_wr     = 0;
    cap_out  = 8'h0;
    cap_wr   = 1'b0;
    cap_fe   = 1'b0;
    cap_pe   = 1'b0;
    cap_ov   = 1'b0;
    cap_busy = 1'b1;
    for (int c = 1; c <= NBITS * 16; c++) begin
      @(negedge clk);
      bus.in = bits[(c - 1) / 16];
      if (c == rst_at) rst = 1'b1;
      @(posedge clk);
      #1;
      if (c == rst_at) begin
        check_zero_outputs("mid_reset");
        break;
      end
      if (bus.done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = c;
          cap_out  = bus.out;
          cap_wr   = bus.fifo_wr_en;
          cap_fe   = bus.frame_err;
          cap_pe   = bus.parity_err;
          cap_ov   = bus.overrun;
          cap_busy = bus.busy;
        end
      end
      if (bus.fifo_wr_en) n_wr++;
    end
    @(negedge clk);
    bus.in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_out,
                             input logic exp_wr, input logic exp_fe,
                             input logic exp_pe, input logic exp_ov);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(EXP_DONE));
    check({tag, "_n_done"},     32'(n_done), 32'd1);
    check({tag, "_n_wr"},       32'(n_wr), 32'(exp_wr));
    check({tag, "_wr"},         32'(cap_wr), 32'(exp_wr));
    check({tag, "_out"},        32'(cap_out), 32'(exp_out));
    check({tag, "_fe"},         32'(cap_fe), 32'(exp_fe));
    check({tag, "_pe"},         32'(cap_pe), 32'(exp_pe));
    check({tag, "_ov"},         32'(cap_ov), 32'(exp_ov));
    check({tag, "_busy"},       32'(cap_busy), 32'd0);
    check({tag, "_out_hold"},   32'(bus.out), 32'(exp_out));
  endtask

  initial begin
    int gl_busy_hi;
    int gl_busy_lo;
    int gl_done;

    rst              = 1'b1;
    bus.in           = 1'b1;
    bus.en           = 1'b1;
    bus.is_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(20, "post_reset");

    // Good byte, FIFO ready.
    run_frame(8'hA5, 1'b1, 1'b0, 0);
    check_frame("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(30, "a5");

    // 4-cycle low glitch on idle line.
    gl_busy_hi = 0;
    gl_busy_lo = 0;
    gl_done    = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.in = (c <= 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (c == 5 && bus.busy) gl_busy_hi = 1;
      if (c == 12 && !bus.busy) gl_busy_lo = 1;
      if (bus.done) gl_done++;
    end
    check("glitch_busy_high", 32'(gl_busy_hi), 32'd1);
    check("glitch_busy_low",  32'(gl_busy_lo), 32'd1);
    check("glitch_no_done",   32'(gl_done), 32'd0);
    idle(30, "glitch");

    // Stop bit low: framing error, previous byte held.
    run_frame(8'h3C, 1'b0, 1'b0, 0);
    check_frame("3c_ferr", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(40, "3c_ferr");

    // FIFO full: overrun, byte dropped.
    bus.is_fifo_full = 1'b1;
    run_frame(8'h81, 1'b1, 1'b0, 0);
    check_frame("81_ovr", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.is_fifo_full = 1'b0;
    idle(30, "81_ovr");

    run_frame(8'h55, 1'b1, 1'b0, 0);
    check_frame("55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(30, "55");

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1.
    run_frame(8'h07, 1'b1, 1'b0, 0);
    check_frame("07_perr", 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(30, "07_perr");
    run_frame(8'h07, 1'b1, 1'b1, 0);
    check_frame("07_ok", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(30, "07_ok");
`endif

    // Receiver disabled: start edges ignored.
    bus.en = 1'b0;
    run_frame(8'h66, 1'b1, 1'b0, 0);
    check("disabled_n_done", 32'(n_done), 32'd0);
    check("disabled_n_wr",   32'(n_wr), 32'd0);
    bus.en = 1'b1;
    idle(30, "disabled");

    // Reset during data bit 4 of 0xFF, then a clean 0x12.
    run_frame(8'hFF, 1'b1, 1'b0, 16 + 4 * 16 + 8);
    idle(20, "after_rst");
    check("after_rst_out", 32'(bus.out), 32'h0);
    run_frame(8'h12, 1'b1, 1'b0, 0);
    check_frame("12", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(30, "12");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
